// File: rtl/counter_updown_param.sv
// counter_updown_param: parametrised up/down counter with a combined
// increment/decrement/re-initialise step each cycle.
// It can either wrap or saturate at the ends of its range. It has
// registered overflow/underflow pulses, sticky error flags, and registered
// zero/max status. value_next is a combinational look-ahead of the next
// count.
// Optional build macro: COUNTER_UPDOWN_THRESHOLD_EN adds a thresh input and
// a registered at_or_above output.

module counter_updown_param #(
    parameter int          WIDTH       = 4,
    parameter int          STEP_WIDTH  = 2,
    parameter int unsigned RESET_VALUE = 0,
    parameter bit          SATURATE    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reinit,
    input  logic [WIDTH-1:0]      initial_value,
    input  logic                  incr_valid,
    input  logic [STEP_WIDTH-1:0] incr,
    input  logic                  decr_valid,
    input  logic [STEP_WIDTH-1:0] decr,
    input  logic                  clr_flags,
`ifdef COUNTER_UPDOWN_THRESHOLD_EN
    input  logic [WIDTH-1:0]      thresh,
`endif
    output logic [WIDTH-1:0]      value,
    output logic [WIDTH-1:0]      value_next,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ovf_sticky,
    output logic                  unf_sticky,
    output logic                  is_zero,
    output logic                  is_max
`ifdef COUNTER_UPDOWN_THRESHOLD_EN
    ,
    output logic                  at_or_above
`endif
);

    // Two extra bits hold the full sum: one for carry above the range and one
    // for the sign when the result goes below zero.
    localparam int RAW_WIDTH = WIDTH + 2;

    localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}};

    logic [WIDTH-1:0]     base;
    logic [RAW_WIDTH-1:0] base_ext;
    logic [RAW_WIDTH-1:0] inc_ext;
    logic [RAW_WIDTH-1:0] dec_ext;
    logic [RAW_WIDTH-1:0] raw;
    logic                 en;
    logic                 ovf_c;
    logic                 unf_c;

    // Form the netted update. Steps whose valid is low are forced to zero,
    // so an X on an unqualified step cannot reach the sum.
    always_comb begin
        base     = reinit ? initial_value : value;
        base_ext = RAW_WIDTH'(base);
        inc_ext  = incr_valid ? RAW_WIDTH'(incr) : '0;
        dec_ext  = decr_valid ? RAW_WIDTH'(decr) : '0;
        raw      = base_ext + inc_ext - dec_ext;
        en       = reinit | incr_valid | decr_valid;
        // The top bit is the sign of the two's-complement result. A set
        // carry bit with a clear sign means the sum went above the range.
        unf_c    = raw[RAW_WIDTH-1];
        ovf_c    = ~raw[RAW_WIDTH-1] & raw[WIDTH];
    end

    // Choose the next count: hold when idle, otherwise wrap or clamp the raw sum.
    always_comb begin
        value_next = value;
        if (en) begin
            if (SATURATE && ovf_c) begin
                value_next = MAX_VAL;
            end else if (SATURATE && unf_c) begin
                value_next = '0;
            end else begin
                value_next = raw[WIDTH-1:0];
            end
        end
    end

    // Register the count and its status. The status is derived from
    // value_next, so it always matches the registered value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value   <= RESET_VAL;
            is_zero <= (RESET_VAL == '0);
            is_max  <= (RESET_VAL == MAX_VAL);
        end else begin
            value   <= value_next;
            is_zero <= (value_next == '0);
            is_max  <= (value_next == MAX_VAL);
        end
    end

    // One-cycle event pulses, plus sticky copies. A set in the same cycle
    // as a clear takes priority over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            ovf_sticky <= 1'b0;
            unf_sticky <= 1'b0;
        end else begin
            overflow   <= en & ovf_c;
            underflow  <= en & unf_c;
            ovf_sticky <= (en & ovf_c) | (ovf_sticky & ~clr_flags);
            unf_sticky <= (en & unf_c) | (unf_sticky & ~clr_flags);
        end
    end

`ifdef COUNTER_UPDOWN_THRESHOLD_EN
    // Registered threshold compare against the look-ahead value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            at_or_above <= 1'b0;
        end else begin
            at_or_above <= (value_next >= thresh);
        end
    end
`endif

endmodule

// File: tb/tb_counter_updown_param.sv
// tb_counter_updown_param: directed test for counter_updown_param.
// wrap_dut  uses WIDTH=4, RESET_VALUE=5 and wrap mode. It runs a vector
// table, then an asynchronous reset in the middle of a cycle, then a hold
// sequence.
// sat_dut uses WIDTH=4, RESET_VALUE=0 and saturate mode. It runs a short
// hand-written sequence.

module tb_counter_updown_param;

    logic       clk;
    logic       rst_n;

    logic       reinit;
    logic [3:0] initial_value;
    logic       incr_valid;
    logic [1:0] incr;
    logic       decr_valid;
    logic [1:0] decr;
    logic       clr_flags;
    logic [3:0] w_value;
    logic [3:0] w_value_next;
    logic       w_overflow;
    logic       w_underflow;
    logic       w_ovf_sticky;
    logic       w_unf_sticky;
    logic       w_is_zero;
    logic       w_is_max;

    logic       s_reinit;
    logic [3:0] s_initial_value;
    logic       s_incr_valid;
    logic [1:0] s_incr;
    logic       s_decr_valid;
    logic [1:0] s_decr;
    logic       s_clr_flags;
    logic [3:0] s_value;
    logic [3:0] s_value_next;
    logic       s_overflow;
    logic       s_underflow;
    logic       s_ovf_sticky;
    logic       s_unf_sticky;
    logic       s_is_zero;
    logic       s_is_max;

`ifdef COUNTER_UPDOWN_THRESHOLD_EN
    logic [3:0] thresh;
    logic       w_at_or_above;
    logic       s_at_or_above;
`endif

    int tests_run;
    int tests_failed;

    typedef struct {
        logic       reinit;
        logic [3:0] init;
        logic       iv;
        logic [1:0] incr;
        logic       dv;
        logic [1:0] decr;
        logic       clr;
        logic [3:0] exp_next;
        logic [3:0] exp_value;
        logic       exp_ovf;
        logic       exp_unf;
        logic       exp_ovs;
        logic       exp_unfs;
        logic       exp_zero;
        logic       exp_max;
    } vec_t;

    vec_t vectors[16];

    counter_updown_param #(
        .WIDTH(4), .STEP_WIDTH(2), .RESET_VALUE(5), .SATURATE(1'b0)
    ) wrap_dut (
        .clk(clk), .rst_n(rst_n), .reinit(reinit), .initial_value(initial_value),
        .incr_valid(incr_valid), .incr(incr), .decr_valid(decr_valid), .decr(decr),
        .clr_flags(clr_flags),
`ifdef COUNTER_UPDOWN_THRESHOLD_EN
        .thresh(thresh),
`endif
        .value(w_value), .value_next(w_value_next), .overflow(w_overflow),
        .underflow(w_underflow), .ovf_sticky(w_ovf_sticky), .unf_sticky(w_unf_sticky),
        .is_zero(w_is_zero), .is_max(w_is_max)
`ifdef COUNTER_UPDOWN_THRESHOLD_EN
        , .at_or_above(w_at_or_above)
`endif
    );

    counter_updown_param #(
        .WIDTH(4), .STEP_WIDTH(2), .RESET_VALUE(0), .SATURATE(1'b1)
    ) sat_dut (
        .clk(clk), .rst_n(rst_n), .reinit(s_reinit), .initial_value(s_initial_value),
        .incr_valid(s_incr_valid), .incr(s_incr), .decr_valid(s_decr_valid), .decr(s_decr),
        .clr_flags(s_clr_flags),
`ifdef COUNTER_UPDOWN_THRESHOLD_EN
        .thresh(thresh),
`endif
        .value(s_value), .value_next(s_value_next), .overflow(s_overflow),
        .underflow(s_underflow), .ovf_sticky(s_ovf_sticky), .unf_sticky(s_unf_sticky),
        .is_zero(s_is_zero), .is_max(s_is_max)
`ifdef COUNTER_UPDOWN_THRESHOLD_EN
        , .at_or_above(s_at_or_above)
`endif
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reinit        = v.reinit;
        initial_value = v.init;
        incr_valid    = v.iv;
        incr          = v.incr;
        decr_valid    = v.dv;
        decr          = v.decr;
        clr_flags     = v.clr;
    endtask

    task automatic idleWrap();
        reinit = 1'b0; initial_value = '0; incr_valid = 1'b0; incr = '0;
        decr_valid = 1'b0; decr = '0; clr_flags = 1'b0;
    endtask

    task automatic idleSat();
        s_reinit = 1'b0; s_initial_value = '0; s_incr_valid = 1'b0; s_incr = '0;
        s_decr_valid = 1'b0; s_decr = '0; s_clr_flags = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
`ifdef COUNTER_UPDOWN_THRESHOLD_EN
        thresh = 4'd8;
`endif

        // Fields: reinit, init, iv, incr, dv, decr, clr,
        //         next, value, ovf, unf, ovs, unfs, zero, max
        vectors[0]  = '{1'b1, 4'd14, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 4'd14, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vectors[1]  = '{1'b0, 4'd0,  1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 4'd1,  4'd1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vectors[2]  = '{1'b0, 4'd0,  1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 4'd1,  4'd1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vectors[3]  = '{1'b0, 4'd0,  1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 4'd14, 4'd14, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vectors[4]  = '{1'b0, 4'd0,  1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 4'd14, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vectors[5]  = '{1'b1, 4'd15, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vectors[6]  = '{1'b0, 4'd0,  1'b1, 2'd2, 1'b1, 2'd2, 1'b0, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vectors[7]  = '{1'b0, 4'd0,  1'b1, 2'd3, 1'b1, 2'd3, 1'b0, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vectors[8]  = '{1'b1, 4'd10, 1'b1, 2'd1, 1'b1, 2'd3, 1'b0, 4'd8,  4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vectors[9]  = '{1'b1, 4'd10, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 4'd10, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vectors[10] = '{1'b0, 4'd0,  1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 4'd13, 4'd13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vectors[11] = '{1'b0, 4'd0,  1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 4'd0,  4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vectors[12] = '{1'b1, 4'd15, 1'b1, 2'd1, 1'b0, 2'd0, 1'b1, 4'd0,  4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vectors[13] = '{1'b0, 4'd0,  1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vectors[14] = '{1'b0, 4'd0,  1'b0, 2'bxx, 1'b1, 2'd1, 1'b0, 4'd15, 4'd15, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vectors[15] = '{1'b0, 4'd0,  1'b1, 2'd1, 1'b0, 2'bxx, 1'b0, 4'd0,  4'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        idleWrap();
        idleSat();
        repeat (2) @(negedge clk);

        checkOutput("wrap reset value", w_value, 4'd5);
        checkOutput("wrap reset zero", w_is_zero, 1'b0);
        checkOutput("wrap reset max", w_is_max, 1'b0);
        checkOutput("wrap reset ovs", w_ovf_sticky, 1'b0);
        checkOutput("sat reset value", s_value, 4'd0);
        checkOutput("sat reset zero", s_is_zero, 1'b1);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            applyStimulus(vectors[i]);
            #1;
            checkOutput($sformatf("vec%0d value_next", i), w_value_next, vectors[i].exp_next);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d value", i), w_value, vectors[i].exp_value);
            checkOutput($sformatf("vec%0d overflow", i), w_overflow, vectors[i].exp_ovf);
            checkOutput($sformatf("vec%0d underflow", i), w_underflow, vectors[i].exp_unf);
            checkOutput($sformatf("vec%0d ovf_sticky", i), w_ovf_sticky, vectors[i].exp_ovs);
            checkOutput($sformatf("vec%0d unf_sticky", i), w_unf_sticky, vectors[i].exp_unfs);
            checkOutput($sformatf("vec%0d is_zero", i), w_is_zero, vectors[i].exp_zero);
            checkOutput($sformatf("vec%0d is_max", i), w_is_max, vectors[i].exp_max);
        end

        // Load 9, then pull reset low partway through the next cycle.
        @(negedge clk);
        idleWrap();
        reinit = 1'b1;
        initial_value = 4'd9;
        @(posedge clk);
        #1;
        checkOutput("pre-reset value", w_value, 4'd9);
        idleWrap();
        incr_valid = 1'b1;
        incr = 2'd3;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset value", w_value, 4'd5);
        checkOutput("async reset ovf_sticky", w_ovf_sticky, 1'b0);
        checkOutput("async reset unf_sticky", w_unf_sticky, 1'b0);
        checkOutput("async reset overflow", w_overflow, 1'b0);
        checkOutput("async reset is_zero", w_is_zero, 1'b0);
        @(negedge clk);
        idleWrap();
        rst_n = 1'b1;

        // Five idle cycles leave the count and the look-ahead untouched.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("hold%0d value", i), w_value, 4'd5);
            checkOutput($sformatf("hold%0d value_next", i), w_value_next, 4'd5);
        end

        // Saturating instance: start from 1 and step down by 3.
        @(negedge clk);
        s_reinit = 1'b1;
        s_initial_value = 4'd1;
        @(posedge clk);
        #1;
        checkOutput("sat load value", s_value, 4'd1);
        @(negedge clk);
        idleSat();
        s_decr_valid = 1'b1;
        s_decr = 2'd3;
        #1;
        checkOutput("sat unf value_next", s_value_next, 4'd0);
        @(posedge clk);
        #1;
        checkOutput("sat unf value", s_value, 4'd0);
        checkOutput("sat unf pulse", s_underflow, 1'b1);
        checkOutput("sat unf sticky", s_unf_sticky, 1'b1);
        checkOutput("sat unf is_zero", s_is_zero, 1'b1);

        // Saturating instance: reinit 14 plus 3 clamps to 15.
        @(negedge clk);
        idleSat();
        s_reinit = 1'b1;
        s_initial_value = 4'd14;
        s_incr_valid = 1'b1;
        s_incr = 2'd3;
        @(posedge clk);
        #1;
        checkOutput("sat ovf value", s_value, 4'd15);
        checkOutput("sat ovf pulse", s_overflow, 1'b1);
        checkOutput("sat ovf underflow", s_underflow, 1'b0);
        checkOutput("sat ovf is_max", s_is_max, 1'b1);
        @(negedge clk);
        idleSat();
        @(posedge clk);
        #1;
        checkOutput("sat pulse drop", s_overflow, 1'b0);
        checkOutput("sat ovf sticky held", s_ovf_sticky, 1'b1);
        checkOutput("sat hold value", s_value, 4'd15);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/counter_updown_param.md
Name: counter_updown_param

Overview:
- Parametrised successor of the 4-bit incr/decr counter.
- Holds a WIDTH-bit value. On each cycle it can add a valid increment, subtract a valid decrement, and/or re-initialise from a port value, all in the same cycle.
- Adds a wrap/saturate mode, registered overflow/underflow pulses, sticky error flags, and registered zero/max status.
- Used wherever credit, occupancy or pointer bookkeeping needs a single-cycle multi-step update with a combinational look-ahead (value_next).

Parameters:
- WIDTH, 4, counter width in bits (2..32).
- STEP_WIDTH, 2, width of the incr and decr step inputs (1..WIDTH).
- RESET_VALUE, 0, value loaded on asynchronous reset (must fit in WIDTH).
- SATURATE, 0, 0 = modulo-2^WIDTH wrap; 1 = clamp to [0, 2^WIDTH-1].

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- reinit  in  1  use initial_value instead of value as the base for this cycle's update.
- initial_value  in  WIDTH  base used when reinit=1.
- incr_valid  in  1  qualifies incr.
- incr  in  STEP_WIDTH  unsigned increment.
- decr_valid  in  1  qualifies decr.
- decr  in  STEP_WIDTH  unsigned decrement.
- clr_flags  in  1  clears the sticky error flags.
- value  out  WIDTH  registered count.
- value_next  out  WIDTH  combinational value that will load on the next edge.
- overflow  out  1  registered one-cycle pulse.
- underflow  out  1  registered one-cycle pulse.
- ovf_sticky  out  1  sticky overflow flag.
- unf_sticky  out  1  sticky underflow flag.
- is_zero  out  1  registered; value == 0.
- is_max  out  1  registered; value == 2^WIDTH-1.

Behaviour:
- Reset: rst_n low asynchronously forces:
  - value = RESET_VALUE
  - overflow, underflow, ovf_sticky, unf_sticky = 0
  - is_zero = (RESET_VALUE == 0)
  - is_max = (RESET_VALUE == 2^WIDTH-1)
- Reset release is synchronous to clk in the surrounding logic. A reset asserted mid-update discards that update.
- Update calculation:
  - base = reinit ? initial_value : value
  - inc = incr_valid ? incr : 0
  - dec = decr_valid ? decr : 0
  - raw = base + inc - dec, computed signed at WIDTH+2 bits; no intermediate truncation.
- Overflow and underflow conditions:
  - ovf_c = raw > 2^WIDTH-1
  - unf_c = raw < 0
  - At most one of the two can be true.
- Result by mode:
  - SATURATE=0: value_next = raw mod 2^WIDTH.
  - SATURATE=1: value_next = 2^WIDTH-1 if ovf_c, 0 if unf_c, else raw.
- Load enable: en = reinit | incr_valid | decr_valid.
  - If en=1, value <= value_next on the edge.
  - If en=0, value holds and value_next == value.
- Simultaneous incr and decr are netted in a single step: incr=3, decr=3 from any base leaves the count unchanged and raises no flag, even at a boundary.
- reinit with valid steps applies the steps to initial_value, not to value.
- overflow and underflow:
  - Each is a registered copy of (en & ovf_c) or (en & unf_c).
  - They are high for exactly the cycle after the offending edge.
  - They fire in both modes.
- Sticky flags:
  - ovf_sticky is set by any overflow pulse condition and held until clr_flags; unf_sticky likewise for underflow.
  - If clr_flags and a new event occur in the same cycle, set wins and the flag stays 1.
- is_zero and is_max are computed from value_next and registered, so they always match the registered value.
- Latency:
  - value_next: 0 cycles.
  - value and status outputs: 1 cycle.
- No X propagation: incr and decr are ignored when their valid is low, even if X.

Optional Feature:
- Macro COUNTER_UPDOWN_THRESHOLD_EN.
- When defined, the block adds:
  - input `thresh` (WIDTH bits)
  - output `at_or_above` (1 bit), registered, equal to (value_next >= thresh), updated every cycle, reset to 0.
- When not defined, neither port exists and there is no associated logic.
- All other behaviour is identical in both builds.

Test Plan:
- Reset (WIDTH=4, RESET_VALUE=5): drop rst_n mid-cycle while value=9 -> value=5 immediately (asynchronously), all flags 0, is_zero=0.
- Wrap mode (SATURATE=0): value=14, incr_valid=1, incr=3 -> value_next=1, value=1 next edge, overflow=1 for one cycle, ovf_sticky=1 until clr_flags.
- Saturate mode (SATURATE=1): value=1, decr_valid=1, decr=3 -> value=0, underflow pulse, is_zero=1. Same case with SATURATE=0 -> value=14.
- Netted update: value=15, incr=2 and decr=2 both valid -> value stays 15, no overflow, is_max=1.
- Reinit: value=7, reinit=1, initial_value=10, incr_valid=1, incr=1, decr_valid=1, decr=3 -> value=8. Same with reinit and both valids low except reinit -> value=10.
- Hold and clear: all enables low for 5 cycles -> value and value_next unchanged. clr_flags asserted in the same cycle as a new overflow -> ovf_sticky stays 1. clr_flags alone -> ovf_sticky=0.
